// File: rtl/regfile_pkg.sv
// Shared datapath widths and register-file constants for the CPU core.
package regfile_pkg;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ZERO_REG = 0;
endpackage

// File: rtl/reg_n_en.sv
// n-bit storage register with synchronous active-high reset and write enable.
module reg_n_en #(
    parameter int unsigned n = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [n-1:0] i_d,
    output logic [n-1:0] o_q
);

    logic [n-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/regfile.sv
// 2**m x n register file: two combinational read ports, one synchronous write port, r0 hardwired.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile
    import regfile_pkg::*;
#(
    parameter int unsigned n = DATA_W,
    parameter int unsigned m = ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         RegWr,
    input  logic [m-1:0] Rw,
    input  logic [n-1:0] busW,
    input  logic [m-1:0] Ra,
    input  logic [m-1:0] Rb,
    output logic [n-1:0] busA,
    output logic [n-1:0] busB
);

    localparam int unsigned Nregs = 2 ** m;

    logic [n-1:0] w_regs [Nregs];

    // r0 has no storage; it is a constant zero on both read ports.
    assign w_regs[ZERO_REG] = '0;

    for (genvar i = 1; i < Nregs; i++) begin : g_reg
        logic w_we;
        assign w_we = RegWr && (Rw == m'(i));

        reg_n_en #(
            .n (n)
        ) u_reg (
            .i_clk (clk),
            .i_rst (rst),
            .i_en  (w_we),
            .i_d   (busW),
            .o_q   (w_regs[i])
        );
    end

`ifdef REGFILE_BYPASS_EN
    logic w_fwd_ok;
    assign w_fwd_ok = RegWr && !rst && (Rw != m'(ZERO_REG));

    always_comb begin
        busA = w_regs[Ra];
        busB = w_regs[Rb];
        if (w_fwd_ok && (Rw == Ra)) begin
            busA = busW;
        end
        if (w_fwd_ok && (Rw == Rb)) begin
            busB = busW;
        end
    end
`else
    always_comb begin
        busA = w_regs[Ra];
        busB = w_regs[Rb];
    end
`endif

endmodule
